seg7_bcd_capture: RTL

Recovers BCD digits from a multiplexed 4-digit 7-segment display bus, the inverse of the team's BCD-to-7-segment convertor. Samples segment lines {a..g} and a one-hot digit enable every clock, requires a pattern to be stable for STABLE_CNT consecutive samples, then decodes it back to BCD. It assembles a 4-digit frame and presents it with a one-cycle valid pulse. Used by display-loopback self-test and by benches checking display driver output.

---
 rtl/seg7_bcd_capture.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seg7_bcd_capture.sv
// Recovers BCD digits from a multiplexed 4-digit 7-segment bus: each one-hot
// digit pattern must be stable for STABLE_CNT samples before it is decoded.
module seg7_bcd_capture #(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [6:0]  seg,
    input  logic [3:0]  dig_en,
    output logic [15:0] bcd,
    output logic [3:0]  digit_err,
    output logic        frame_valid
);

    localparam logic [7:0] STABLE = 8'(STABLE_CNT);

    logic [10:0] prev;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic [3:0]  shadow_val [4];
    logic [3:0]  shadow_err;
    logic [3:0]  mask;
    logic [3:0]  mask_nxt;
    logic        onehot;
    logic        same;
    logic        capture;
    logic [3:0]  dec_val;
    logic        dec_err;
    logic [15:0] frame_bcd;
    logic [3:0]  frame_err;

    always_comb begin
        onehot = (dig_en == 4'b0001) || (dig_en == 4'b0010) ||
                 (dig_en == 4'b0100) || (dig_en == 4'b1000);
    end

    always_comb begin
        dec_err = 1'b0;
        case (seg)
            7'b1111110: dec_val = 4'd0;
            7'b0110000: dec_val = 4'd1;
            7'b1101101: dec_val = 4'd2;
            7'b1111001: dec_val = 4'd3;
            7'b0110011: dec_val = 4'd4;
            7'b1011011: dec_val = 4'd5;
            7'b1011111: dec_val = 4'd6;
            7'b1110000: dec_val = 4'd7;
            7'b1111111: dec_val = 4'd8;
            7'b1111011: dec_val = 4'd9;
            default: begin
                dec_val = 4'hF;
                dec_err = 1'b1;
            end
        endcase
    end

    // A capture is the first edge of a stable run reaching STABLE; with
    // STABLE_CNT=1 a fresh run arrives at cnt=1 while cnt is already 1, so
    // "held and saturated" is excluded rather than testing cnt < STABLE.
    always_comb begin
        same = ({seg, dig_en} == prev) && (cnt != 8'd0);
        if (!en || !onehot)
            cnt_nxt = 8'd0;
        else if (same)
            cnt_nxt = (cnt == STABLE) ? STABLE : cnt + 8'd1;
        else
            cnt_nxt = 8'd1;
        capture  = en && onehot && (cnt_nxt == STABLE) && !(same && (cnt == STABLE));
        mask_nxt = mask | dig_en;
    end

    always_comb begin
        frame_bcd = '0;
        frame_err = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (capture && dig_en[i]) begin
                frame_bcd[4*i +: 4] = dec_val;
                frame_err[i]        = dec_err;
            end else begin
                frame_bcd[4*i +: 4] = shadow_val[i];
                frame_err[i]        = shadow_err[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev        <= '0;
            cnt         <= '0;
            mask        <= '0;
            shadow_err  <= '0;
            bcd         <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
            for (int unsigned i = 0; i < 4; i++)
                shadow_val[i] <= '0;
        end else begin
            frame_valid <= 1'b0;
            cnt         <= cnt_nxt;
            if (en)
                prev <= {seg, dig_en};
            if (capture) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (dig_en[i]) begin
                        shadow_val[i] <= dec_val;
                        shadow_err[i] <= dec_err;
                    end
                end
                if (mask_nxt == 4'b1111) begin
                    bcd         <= frame_bcd;
                    digit_err   <= frame_err;
                    frame_valid <= 1'b1;
                    mask        <= '0;
                end else begin
                    mask <= mask_nxt;
                end
            end
        end
    end

endmodule
